// File: rtl/bsg_aes_pkg.sv
// rtl/bsg_aes_pkg.sv - shared AES constants, FSM state type and GF(2^8) helpers
package bsg_aes_pkg;

  localparam int aes_num_rounds_gp  = 14;
  localparam int aes_block_width_gp = 128;

  typedef enum logic [1:0] {
    e_wait = 2'd0,
    e_busy = 2'd1,
    e_done = 2'd2
  } state_e;

  // Inverse S-box, entry 0 in the most significant byte
  localparam logic [0:255][7:0] inv_sbox_table = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return inv_sbox_table[x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul11(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul13(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul14(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // One column of InvMixColumns; byte 0 of the column is the MSB
  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3),
            gf_mul9(a0)  ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3),
            gf_mul13(a0) ^ gf_mul9(a1)  ^ gf_mul14(a2) ^ gf_mul11(a3),
            gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2)  ^ gf_mul14(a3)};
  endfunction

endpackage

// File: rtl/bsg_aes_inv_round.sv
// rtl/bsg_aes_inv_round.sv - one combinational AES inverse round
module bsg_aes_inv_round
  import bsg_aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] round_key_i,
  input  logic         last_i,
  output logic [127:0] state_o
);

  logic [127:0] shifted;
  logic [127:0] subbed;
  logic [127:0] keyed;
  logic [127:0] mixed;

  // InvShiftRows: byte at row r, column c comes from column (c - r) mod 4
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127-8*(4*c+r) -: 8] = state_i[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
  end

  // InvSubBytes on all sixteen bytes
  always_comb begin
    subbed = '0;
    for (int i = 0; i < 16; i++) begin
      subbed[127-8*i -: 8] = inv_sbox(shifted[127-8*i -: 8]);
    end
  end

  assign keyed = subbed ^ round_key_i;

  // InvMixColumns applied column by column
  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = inv_mix_column(keyed[127-32*c -: 32]);
    end
  end

  // The final round (r == 0) has no InvMixColumns
  assign state_o = last_i ? keyed : mixed;

endmodule

// File: rtl/bsg_aes_decrypt.sv
// rtl/bsg_aes_decrypt.sv - iterative AES-256 decrypt, ready/valid/yumi; BSG_AES_DECRYPT_TWO_ROUNDS_EN chains two rounds per cycle
module bsg_aes_decrypt
  import bsg_aes_pkg::*;
#(
  parameter int block_width_p = aes_block_width_gp,
  parameter int num_rounds_p  = aes_num_rounds_gp
) (
  input  logic                                        clk_i,
  input  logic                                        reset_i,
  input  logic [block_width_p*(num_rounds_p+2)-1:0]   data_i,
  input  logic                                        v_i,
  output logic                                        ready_o,
  output logic [block_width_p-1:0]                    data_o,
  output logic                                        v_o,
  input  logic                                        yumi_i
);

  localparam logic [1:0] st_wait = e_wait;
  localparam logic [1:0] st_busy = e_busy;
  localparam logic [1:0] st_done = e_done;

  localparam int         key_width_lp    = block_width_p * (num_rounds_p + 1);
  localparam int         in_width_lp     = block_width_p * (num_rounds_p + 2);
  localparam logic [3:0] counter_init_lp = 4'(num_rounds_p - 1);

  logic [1:0]                                fsm_r;
  logic [3:0]                                counter_r;
  logic [block_width_p-1:0]                  state_r;
  logic [block_width_p-1:0]                  data_r;
  logic [block_width_p-1:0]                  round_out;
  logic [0:num_rounds_p][block_width_p-1:0]  key_r;
  logic                                      accept;
  logic                                      last_step;
  logic [3:0]                                counter_step;

  assign ready_o = (fsm_r == st_wait);
  assign v_o     = (fsm_r == st_done);
  assign data_o  = data_r;
  assign accept  = v_i & ready_o;

`ifdef BSG_AES_DECRYPT_TWO_ROUNDS_EN
  logic [3:0]               counter_m1;
  logic [block_width_p-1:0] mid_state;

  assign counter_m1   = counter_r - 4'd1;
  assign counter_step = 4'd2;
  // Counter runs 13, 11, ..., 1; the pair (1, 0) is the last one
  assign last_step    = (counter_r == 4'd1);

  bsg_aes_inv_round round_hi (
    .state_i    (state_r),
    .round_key_i(key_r[counter_r]),
    .last_i     (1'b0),
    .state_o    (mid_state)
  );

  bsg_aes_inv_round round_lo (
    .state_i    (mid_state),
    .round_key_i(key_r[counter_m1]),
    .last_i     (counter_m1 == 4'd0),
    .state_o    (round_out)
  );
`else
  assign counter_step = 4'd1;
  assign last_step    = (counter_r == 4'd0);

  bsg_aes_inv_round round_only (
    .state_i    (state_r),
    .round_key_i(key_r[counter_r]),
    .last_i     (last_step),
    .state_o    (round_out)
  );
`endif

  // Key chain is captured once per block and only read while BUSY
  always_ff @(posedge clk_i) begin
    if (accept) begin
      key_r <= data_i[key_width_lp-1:0];
    end
  end

  // Control FSM, round counter, working state and held result
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fsm_r     <= st_wait;
      counter_r <= '0;
      state_r   <= '0;
      data_r    <= '0;
    end else begin
      case (fsm_r)
        st_wait: begin
          if (accept) begin
            state_r   <= data_i[in_width_lp-1 -: block_width_p] ^ data_i[block_width_p-1:0];
            counter_r <= counter_init_lp;
            fsm_r     <= st_busy;
          end
        end
        st_busy: begin
          state_r <= round_out;
          if (last_step) begin
            data_r    <= round_out;
            counter_r <= '0;
            fsm_r     <= st_done;
          end else begin
            counter_r <= counter_r - counter_step;
          end
        end
        st_done: begin
          if (yumi_i) begin
            fsm_r <= st_wait;
          end
        end
        default: fsm_r <= st_wait;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_aes_decrypt.sv
// tb/tb_bsg_aes_decrypt.sv - scoreboard bench for bsg_aes_decrypt against an independent AES-256 model
module tb_bsg_aes_decrypt;

`ifdef BSG_AES_DECRYPT_TWO_ROUNDS_EN
  localparam int lat = 8;
  localparam int thr = 9;
`else
  localparam int lat = 15;
  localparam int thr = 16;
`endif

  logic          clk;
  logic          reset_i;
  logic [2047:0] data_i;
  logic          v_i;
  logic          ready_o;
  logic [127:0]  data_o;
  logic          v_o;
  logic          yumi_i;
  logic          yumi_auto;
  logic          yumi_man;

  assign yumi_i = yumi_auto ? v_o : yumi_man;

  bsg_aes_decrypt dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .data_i (data_i),
    .v_i    (v_i),
    .ready_o(ready_o),
    .data_o (data_o),
    .v_o    (v_o),
    .yumi_i (yumi_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [127:0] pt;
    int           acc;
  } exp_t;

  exp_t         exp_q[$];
  logic [127:0] stim_exp;
  logic [127:0] held;
  bit           prev_v = 1'b0;
  bit           b2b_mode = 1'b0;
  int           last_rise = -1;
  int           x_seen = 0;

  logic [7:0] sb [256];
  logic [7:0] isb [256];

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b};
    return t[15-n -: 8];
  endfunction

  // S-box from first principles: multiplicative inverse then affine map
  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sb[x] = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  function automatic logic [1919:0] expand_key(input logic [255:0] key);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] ch;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = subword(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int k = 0; k < 15; k++) ch[1919-128*k -: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    return ch;
  endfunction

  function automatic logic [127:0] m_encrypt(input logic [127:0] pt, input logic [1919:0] ch);
    logic [127:0] s, t, u, m;
    logic [7:0]   a0, a1, a2, a3;
    s = pt ^ ch[1919 -: 128];
    for (int r = 1; r <= 14; r++) begin
      for (int b = 0; b < 16; b++) t[127-8*b -: 8] = sb[s[127-8*b -: 8]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++)
          u[127-8*(4*c+rw) -: 8] = t[127-8*(4*((c+rw)%4)+rw) -: 8];
      m = u;
      if (r < 14) begin
        for (int c = 0; c < 4; c++) begin
          a0 = u[127-32*c -: 8];
          a1 = u[119-32*c -: 8];
          a2 = u[111-32*c -: 8];
          a3 = u[103-32*c -: 8];
          m[127-32*c -: 32] = {gmul(a0,8'h02) ^ gmul(a1,8'h03) ^ a2 ^ a3,
                               a0 ^ gmul(a1,8'h02) ^ gmul(a2,8'h03) ^ a3,
                               a0 ^ a1 ^ gmul(a2,8'h02) ^ gmul(a3,8'h03),
                               gmul(a0,8'h03) ^ a1 ^ a2 ^ gmul(a3,8'h02)};
        end
      end
      s = m ^ ch[1919-128*r -: 128];
    end
    return s;
  endfunction

  function automatic logic [127:0] m_decrypt(input logic [127:0] ct, input logic [1919:0] ch);
    logic [127:0] s, u, t, m;
    logic [7:0]   a0, a1, a2, a3;
    s = ct ^ ch[127:0];
    for (int r = 13; r >= 0; r--) begin
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++)
          u[127-8*(4*c+rw) -: 8] = s[127-8*(4*((c-rw+4)%4)+rw) -: 8];
      for (int b = 0; b < 16; b++) t[127-8*b -: 8] = isb[u[127-8*b -: 8]];
      t = t ^ ch[1919-128*r -: 128];
      m = t;
      if (r > 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[127-32*c -: 8];
          a1 = t[119-32*c -: 8];
          a2 = t[111-32*c -: 8];
          a3 = t[103-32*c -: 8];
          m[127-32*c -: 32] = {gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09),
                               gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d),
                               gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b),
                               gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e)};
        end
      end
      s = m;
    end
    return s;
  endfunction

  // Monitor: pushes expectations at each accept, pops and compares at each new result
  always @(negedge clk) begin
    exp_t e;
    if (reset_i) begin
      exp_q.delete();
      prev_v = 1'b0;
    end else begin
      if ($isunknown({data_o, v_o, ready_o})) x_seen++;
      if (v_o) begin
        if (!prev_v) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result actual=%h required=none", data_o);
          end else begin
            e = exp_q.pop_front();
            check128("plaintext", data_o, e.pt);
            check_int("latency", cyc - e.acc, lat);
            if (b2b_mode && last_rise >= 0) check_int("interval", cyc - last_rise, thr);
          end
          last_rise = cyc;
          held = data_o;
        end else begin
          check128("data_hold", data_o, held);
        end
      end
      prev_v = v_o;
      if (v_i && ready_o) begin
        e.pt  = stim_exp;
        e.acc = cyc;
        exp_q.push_back(e);
      end
    end
  end

  task automatic send(input logic [127:0] ct, input logic [1919:0] ch, input logic [127:0] pt);
    bit got;
    int n;
    data_i   = {ct, ch};
    stim_exp = pt;
    v_i      = 1'b1;
    got      = 1'b0;
    n        = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      got = ready_o;
      @(posedge clk);
      #1;
      n++;
    end
    v_i = 1'b0;
    if (!got) fail_now("accept_timeout");
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) fail_now("result_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic rand_vec(output logic [127:0] ct, output logic [1919:0] ch, output logic [127:0] pt);
    logic [255:0] key;
    pt  = {$urandom, $urandom, $urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    ch  = expand_key(key);
    ct  = m_encrypt(pt, ch);
  endtask

  initial begin
    logic [1919:0] ch;
    logic [127:0]  ct, pt;
    int            idx, n;
    bit            acc;

    reset_i   = 1'b1;
    v_i       = 1'b0;
    data_i    = '0;
    yumi_auto = 1'b1;
    yumi_man  = 1'b0;
    stim_exp  = '0;
    build_tables();

    repeat (2) @(posedge clk);
    #1;
    check_int("reset_ready", int'(ready_o), 1);
    check_int("reset_valid", int'(v_o), 0);
    check128("reset_data", data_o, 128'h0);
    reset_i = 1'b0;
    @(posedge clk);
    #1;

    // FIPS-197 C.3
    ch = expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    check128("model_fips_ct", m_encrypt(128'h00112233445566778899aabbccddeeff, ch),
             128'h8ea2b7ca516745bfeafc49904b496089);
    send(128'h8ea2b7ca516745bfeafc49904b496089, ch, 128'h00112233445566778899aabbccddeeff);
    wait_result();

    // Backpressure in DONE with ignored v_i pulses
    yumi_auto = 1'b0;
    yumi_man  = 1'b0;
    rand_vec(ct, ch, pt);
    send(ct, ch, pt);
    n = 0;
    while (!v_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!v_o) fail_now("bp_valid_timeout");
    for (int i = 0; i < 20; i++) begin
      v_i    = (i % 4 == 1);
      data_i = {$urandom, 2016'h0};
      @(negedge clk);
      check_int("bp_ready", int'(ready_o), 0);
      check_int("bp_valid", int'(v_o), 1);
      @(posedge clk);
      #1;
    end
    v_i      = 1'b0;
    yumi_man = 1'b1;
    @(posedge clk);
    #1;
    yumi_man  = 1'b0;
    yumi_auto = 1'b1;
    check_int("after_yumi_ready", int'(ready_o), 1);
    check_int("after_yumi_valid", int'(v_o), 0);

    // Reset in cycle N+5 of a block
    rand_vec(ct, ch, pt);
    send(ct, ch, pt);
    repeat (4) @(posedge clk);
    #1;
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    check_int("midrst_ready", int'(ready_o), 1);
    check_int("midrst_valid", int'(v_o), 0);
    check128("midrst_data", data_o, 128'h0);
    rand_vec(ct, ch, pt);
    send(ct, ch, pt);
    wait_result();

    // All-zero key and ciphertext
    ch = expand_key(256'h0);
    send(128'h0, ch, m_decrypt(128'h0, ch));
    wait_result();

    // Back-to-back loopback of random pairs with yumi tied to v_o
    b2b_mode  = 1'b1;
    last_rise = -1;
    idx       = 0;
    n         = 0;
    rand_vec(ct, ch, pt);
    data_i    = {ct, ch};
    stim_exp  = pt;
    v_i       = 1'b1;
    while (idx < 1000 && n < 1000 * thr + 200) begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #1;
      n++;
      if (acc) begin
        idx++;
        if (idx < 1000) begin
          rand_vec(ct, ch, pt);
          data_i   = {ct, ch};
          stim_exp = pt;
        end else begin
          v_i = 1'b0;
        end
      end
    end
    v_i = 1'b0;
    if (idx < 1000) fail_now("b2b_timeout");
    wait_result();
    b2b_mode = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_int("no_x_on_outputs", x_seen, 0);
    check_int("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
